// File: rtl/lane_test_pkg.sv
// Shared definitions for the lane pattern test engine: mode encodings, the
// PRBS7 tap set and the per-lane LFSR seed/step helpers.
package lane_test_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_WALK  = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;
  localparam logic [1:0] MODE_PRBS  = 2'd3;

  // x^7 + x^6 + 1: feedback is bit 6 xor bit 5.
  localparam logic [6:0] PRBS_TAP = 7'b110_0000;

  function automatic logic [6:0] lfsr_seed(input int lane);
    return 7'((lane % 127) + 1);
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS_TAP)};
  endfunction

endpackage

// File: rtl/lane_checker.sv
// Per-lane error accumulator: registered mismatch, saturating counter and a
// sticky error flag. A clear always beats an increment in the same cycle.
module lane_checker
  import lane_test_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             hit,
  output logic [ERR_W-1:0] count,
  output logic             mask
);

  localparam logic [ERR_W-1:0] COUNT_MAX = '1;

  logic mism;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mism  <= 1'b0;
      count <= '0;
      mask  <= 1'b0;
    end else begin
      mism <= hit;
      if (clear) begin
        count <= '0;
        mask  <= 1'b0;
      end else if (mism) begin
        mask <= 1'b1;
        if (count != COUNT_MAX) count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_pattern_test.sv
// Multi-lane pattern generator and loopback checker: drives walking-one,
// counter or per-lane PRBS7 on tx and scores looped-back rx per lane.
module lane_pattern_test
  import lane_test_pkg::*;
#(
  parameter int NLANE    = 8,
  parameter int LOOP_LAT = 2,
  parameter int DWELL    = 16,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       mode,
  input  logic             clear,
  input  logic [NLANE-1:0] rx,
  input  logic [5:0]       rd_lane,
  output logic [NLANE-1:0] tx,
  output logic             oe,
  output logic             blank,
  output logic [NLANE-1:0] err_mask,
  output logic [ERR_W-1:0] rd_count
);

  localparam int BLANK_W = 5;
  // Covers the change cycle plus LOOP_LAT+1 cycles after the first new word.
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(LOOP_LAT + 2);

  logic [1:0]         mode_r;
  logic               mode_chg;
  logic [5:0]         walk_idx;
  logic [31:0]        dwell_cnt;
  logic [NLANE-1:0]   count_q;
  logic [6:0]         lfsr [NLANE];
  logic [NLANE-1:0]   pattern;
  logic [NLANE-1:0]   exp_pipe [LOOP_LAT];
  logic [NLANE-1:0]   exp_word;
  logic [BLANK_W-1:0] blank_cnt;
  logic [ERR_W-1:0]   counts [NLANE];
  logic [ERR_W-1:0]   rd_sel;

  assign mode_chg = (mode != mode_r);
  assign exp_word = exp_pipe[LOOP_LAT-1];

  // Generators reload on the edge where mode_r takes its new value, so the
  // initial state is the first word presented on tx one edge later.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_r    <= MODE_OFF;
      walk_idx  <= '0;
      dwell_cnt <= '0;
      count_q   <= '0;
      for (int i = 0; i < NLANE; i++) lfsr[i] <= lfsr_seed(i);
    end else begin
      mode_r <= mode;
      if (mode_chg) begin
        walk_idx  <= '0;
        dwell_cnt <= '0;
        count_q   <= '0;
        for (int i = 0; i < NLANE; i++) lfsr[i] <= lfsr_seed(i);
      end else begin
        case (mode_r)
          MODE_WALK: begin
            if (dwell_cnt == 32'(DWELL - 1)) begin
              dwell_cnt <= '0;
              walk_idx  <= (walk_idx == 6'(NLANE - 1)) ? '0 : walk_idx + 1'b1;
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
          MODE_COUNT: count_q <= count_q + 1'b1;
          MODE_PRBS:  for (int i = 0; i < NLANE; i++) lfsr[i] <= lfsr_step(lfsr[i]);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    pattern = '0;
    case (mode_r)
      MODE_WALK:  pattern = NLANE'(1) << walk_idx;
      MODE_COUNT: pattern = count_q;
      MODE_PRBS:  for (int i = 0; i < NLANE; i++) pattern[i] = lfsr[i][6];
      default:    pattern = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx        <= '0;
      oe        <= 1'b0;
      blank     <= 1'b1;
      blank_cnt <= '0;
      for (int j = 0; j < LOOP_LAT; j++) exp_pipe[j] <= '0;
    end else begin
      tx          <= pattern;
      oe          <= (mode_r != MODE_OFF);
      exp_pipe[0] <= tx;
      for (int j = 1; j < LOOP_LAT; j++) exp_pipe[j] <= exp_pipe[j-1];
      if (mode_chg) begin
        blank     <= 1'b1;
        blank_cnt <= BLANK_LOAD;
      end else begin
        if (blank_cnt != '0) blank_cnt <= blank_cnt - 1'b1;
        blank <= (mode_r == MODE_OFF) || (blank_cnt > BLANK_W'(1));
      end
    end
  end

  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    lane_checker #(.ERR_W(ERR_W)) u_chk (
      .clk   (clk),
      .rstn  (rstn),
      .clear (clear),
      .hit   ((rx[g] ^ exp_word[g]) & ~blank),
      .count (counts[g]),
      .mask  (err_mask[g])
    );
  end

  // Lane selects beyond NLANE fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NLANE; i++)
      if (rd_lane == 6'(i)) rd_sel = counts[i];
  end

  always_ff @(posedge clk) begin
    if (!rstn) rd_count <= '0;
    else       rd_count <= rd_sel;
  end

endmodule

// File: tb/tb_lane_pattern_test.sv
// Bench for lane_pattern_test: loopback wire model, pattern reference built
// from the mode rules, and scenario tasks run in sequence.
module tb_lane_pattern_test;

  localparam int NLANE    = 8;
  localparam int LOOP_LAT = 2;
  localparam int DWELL    = 4;
  localparam int ERR_W    = 16;
  localparam int SAT_W    = 4;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_WALK  = 2'd1;
  localparam logic [1:0] M_COUNT = 2'd2;
  localparam logic [1:0] M_PRBS  = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn, clear;
  logic [1:0]       mode;
  logic [NLANE-1:0] rx, rx_sat;
  logic [5:0]       rd_lane;
  logic [NLANE-1:0] tx, err_mask, tx_sat, err_mask_sat;
  logic             oe, blank, oe_sat, blank_sat;
  logic [ERR_W-1:0] rd_count;
  logic [SAT_W-1:0] rd_count_sat;

  lane_pattern_test #(.NLANE(NLANE), .LOOP_LAT(LOOP_LAT), .DWELL(DWELL), .ERR_W(ERR_W)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .clear(clear), .rx(rx), .rd_lane(rd_lane),
    .tx(tx), .oe(oe), .blank(blank), .err_mask(err_mask), .rd_count(rd_count));

  lane_pattern_test #(.NLANE(NLANE), .LOOP_LAT(LOOP_LAT), .DWELL(DWELL), .ERR_W(SAT_W)) dut_sat (
    .clk(clk), .rstn(rstn), .mode(mode), .clear(clear), .rx(rx_sat), .rd_lane(rd_lane),
    .tx(tx_sat), .oe(oe_sat), .blank(blank_sat), .err_mask(err_mask_sat), .rd_count(rd_count_sat));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [NLANE-1:0] stuck0 = '0;
  logic [NLANE-1:0] flip = '0;
  logic [NLANE-1:0] hist[$];
  logic [NLANE-1:0] hist_sat[$];
  bit               prbs_seq [NLANE][127];

  always @(posedge clk) cyc++;

  // Loopback wire: rx is tx delayed LOOP_LAT cycles, with optional faults.
  always @(negedge clk) begin
    hist.push_back(tx);
    hist_sat.push_back(tx_sat);
    if (hist.size() > LOOP_LAT + 1) void'(hist.pop_front());
    if (hist_sat.size() > LOOP_LAT + 1) void'(hist_sat.pop_front());
    rx     = (hist.size() == LOOP_LAT + 1) ? ((hist[0] ^ flip) & ~stuck0) : '0;
    rx_sat = (hist_sat.size() == LOOP_LAT + 1) ? ~hist_sat[0] : '0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [NLANE-1:0] model_word(input logic [1:0] m, input int t);
    logic [NLANE-1:0] w;
    w = '0;
    case (m)
      M_WALK:  w[(t / DWELL) % NLANE] = 1'b1;
      M_COUNT: w = NLANE'(t);
      M_PRBS:  for (int i = 0; i < NLANE; i++) w[i] = prbs_seq[i][t % 127];
      default: w = '0;
    endcase
    return w;
  endfunction

  task automatic build_prbs();
    logic [6:0] s;
    for (int i = 0; i < NLANE; i++) begin
      s = 7'((i % 127) + 1);
      for (int t = 0; t < 127; t++) begin
        prbs_seq[i][t] = s[6];
        s = {s[5:0], s[6] ^ s[5]};
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m, output int start);
    mode  = m;
    start = cyc + 2;
  endtask

  task automatic test_reset();
    rstn = 1'b0; mode = M_OFF; clear = 1'b0; rd_lane = '0;
    step(); step();
    checks++; if (tx !== '0) begin errors++; $display("FAIL reset_tx got %h want 00", tx); end
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", oe); end
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b want 1", blank); end
    checks++; if (err_mask !== '0) begin errors++; $display("FAIL reset_mask got %h want 00", err_mask); end
    checks++; if (rd_count !== '0) begin errors++; $display("FAIL reset_rd_count got %0d want 0", rd_count); end
    rstn = 1'b1;
    step(); step();
    checks++; if (blank !== 1'b1 || oe !== 1'b0) begin errors++; $display("FAIL off_state blank=%b oe=%b want 1/0", blank, oe); end
  endtask

  task automatic test_walk();
    int start, t;
    logic [NLANE-1:0] w;
    set_mode(M_WALK, start);
    step();
    checks++; if (blank !== 1'b1 || tx !== '0) begin errors++; $display("FAIL walk_change blank=%b tx=%h want 1/00", blank, tx); end
    for (int k = 0; k < 12 * DWELL; k++) begin
      step();
      t = cyc - start;
      w = model_word(M_WALK, t);
      checks++; if (tx !== w) begin errors++; $display("FAIL walk_tx t=%0d got %h want %h", t, tx, w); end
      checks++; if (oe !== 1'b1) begin errors++; $display("FAIL walk_oe t=%0d got %b want 1", t, oe); end
      checks++; if (blank !== (t <= LOOP_LAT)) begin errors++; $display("FAIL walk_blank t=%0d got %b want %b", t, blank, t <= LOOP_LAT); end
    end
    for (int i = 0; i < NLANE; i++) begin
      rd_lane = 6'(i);
      step();
      checks++; if (rd_count !== '0) begin errors++; $display("FAIL walk_count lane=%0d got %0d want 0", i, rd_count); end
    end
    checks++; if (err_mask !== '0) begin errors++; $display("FAIL walk_mask got %h want 00", err_mask); end
  endtask

  task automatic test_mode_change();
    int start, t;
    logic [NLANE-1:0] w;
    flip = 8'h20;
    step(); step(); step();
    flip = '0;
    repeat (4) step();
    rd_lane = 6'd5;
    step();
    checks++; if (rd_count !== 16'd3) begin errors++; $display("FAIL pre_change_count got %0d want 3", rd_count); end
    set_mode(M_COUNT, start);
    step();
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL change_blank_first got %b want 1", blank); end
    for (int k = 0; k < 30; k++) begin
      step();
      t = cyc - start;
      w = model_word(M_COUNT, t);
      checks++; if (tx !== w) begin errors++; $display("FAIL count_tx t=%0d got %h want %h", t, tx, w); end
      checks++; if (blank !== (t <= LOOP_LAT)) begin errors++; $display("FAIL count_blank t=%0d got %b want %b", t, blank, t <= LOOP_LAT); end
    end
    for (int i = 0; i < NLANE; i++) begin
      rd_lane = 6'(i);
      step();
      checks++; if (rd_count !== ((i == 5) ? 16'd3 : 16'd0)) begin
        errors++; $display("FAIL change_count lane=%0d got %0d want %0d", i, rd_count, (i == 5) ? 3 : 0);
      end
    end
    checks++; if (err_mask !== 8'h20) begin errors++; $display("FAIL change_mask got %h want 20", err_mask); end
  endtask

  task automatic test_clear();
    rd_lane = 6'd0;
    clear = 1'b1; step(); clear = 1'b0;
    flip = 8'h01; step(); step(); flip = '0;
    repeat (4) step();
    checks++; if (rd_count !== 16'd2) begin errors++; $display("FAIL clear_pre got %0d want 2", rd_count); end
    flip = 8'h01;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0; flip = '0;
    step();
    checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL clear_wins got %0d want 0", rd_count); end
    step();
    checks++; if (rd_count !== 16'd1) begin errors++; $display("FAIL clear_next got %0d want 1", rd_count); end
    repeat (3) step();
    checks++; if (err_mask !== 8'h01) begin errors++; $display("FAIL clear_mask got %h want 01", err_mask); end
    rd_lane = 6'd5;
    step();
    checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL clear_lane5 got %0d want 0", rd_count); end
  endtask

  task automatic test_saturation();
    logic [SAT_W-1:0] want;
    rd_lane = 6'd0;
    step();
    clear = 1'b1; step(); clear = 1'b0;
    for (int m = 1; m <= 22; m++) begin
      step();
      want = SAT_W'((m - 1 > 15) ? 15 : m - 1);
      checks++; if (rd_count_sat !== want) begin errors++; $display("FAIL sat_ramp m=%0d got %0d want %0d", m, rd_count_sat, want); end
    end
    for (int i = 0; i < NLANE; i++) begin
      rd_lane = 6'(i);
      step();
      checks++; if (rd_count_sat !== 4'd15) begin errors++; $display("FAIL sat_hold lane=%0d got %0d want 15", i, rd_count_sat); end
    end
    checks++; if (err_mask_sat !== 8'hFF) begin errors++; $display("FAIL sat_mask got %h want ff", err_mask_sat); end
    checks++; if (err_mask !== '0) begin errors++; $display("FAIL sat_main_mask got %h want 00", err_mask); end
  endtask

  task automatic test_prbs();
    int start, t, ones;
    logic [NLANE-1:0] w;
    clear = 1'b1; step(); clear = 1'b0;
    set_mode(M_PRBS, start);
    step();
    stuck0 = 8'h08;
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL prbs_blank_first got %b want 1", blank); end
    for (int k = 0; k <= LOOP_LAT + 1000; k++) begin
      step();
      t = cyc - start;
      w = model_word(M_PRBS, t);
      checks++; if (tx !== w) begin errors++; $display("FAIL prbs_tx t=%0d got %h want %h", t, tx, w); end
      checks++; if (blank !== (t <= LOOP_LAT)) begin errors++; $display("FAIL prbs_blank t=%0d got %b want %b", t, blank, t <= LOOP_LAT); end
    end
    step();
    stuck0 = '0;
    ones = 0;
    for (int tt = 1; tt <= 1000; tt++) ones += int'(prbs_seq[3][tt % 127]);
    repeat (4) step();
    for (int i = 0; i < NLANE; i++) begin
      rd_lane = 6'(i);
      step();
      checks++; if (rd_count !== ((i == 3) ? 16'(ones) : 16'd0)) begin
        errors++; $display("FAIL prbs_count lane=%0d got %0d want %0d", i, rd_count, (i == 3) ? ones : 0);
      end
    end
    checks++; if (err_mask !== 8'h08) begin errors++; $display("FAIL prbs_mask got %h want 08", err_mask); end
    rd_lane = 6'd9;
    step();
    checks++; if (rd_count !== '0) begin errors++; $display("FAIL rd_lane_oob got %0d want 0", rd_count); end
    rd_lane = 6'd3;
    step();
  endtask

  task automatic test_reset_mid_run();
    rd_lane = 6'($urandom_range(0, 7));
    step();
    rd_lane = 6'd3;
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    checks++; if (tx !== '0) begin errors++; $display("FAIL mid_reset_tx got %h want 00", tx); end
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL mid_reset_oe got %b want 0", oe); end
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL mid_reset_blank got %b want 1", blank); end
    checks++; if (err_mask !== '0) begin errors++; $display("FAIL mid_reset_mask got %h want 00", err_mask); end
    checks++; if (rd_count !== '0) begin errors++; $display("FAIL mid_reset_rd_count got %0d want 0", rd_count); end
    checks++; if (rd_count_sat !== '0 || err_mask_sat !== '0) begin
      errors++; $display("FAIL mid_reset_sat count=%0d mask=%h want 0/00", rd_count_sat, err_mask_sat);
    end
    rd_lane = 6'd9;
    step(); step();
    checks++; if (rd_count !== '0) begin errors++; $display("FAIL post_reset_oob got %0d want 0", rd_count); end
  endtask

  initial begin
    build_prbs();
    test_reset();
    test_walk();
    test_mode_change();
    test_clear();
    test_saturation();
    test_prbs();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
